// File: rtl/spi_master_multi.sv
// Single-word SPI master: mode, bit order, divider and slave index are latched
// when a transfer is accepted, so the inputs are free to change mid-transfer.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int DIV_W  = 8,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SS_n
);
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  cnt, cnt_next, div;
  logic [HALF_W-1:0] half, half_next;
  logic              half_end, accept, lead, trail, finish;
  logic              cpol_l, cpha_l, lsb_l;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [NUM_SS-1:0] ss_dec;

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign half_end = (cnt == div);

  // Slave-select decode; an index beyond NUM_SS selects no slave at all.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (32'(ss_sel) == i) ss_dec[i] = 1'b0;
      else                  ss_dec[i] = 1'b1;
    end
  end

  // Next-state logic and the per-cycle SCLK edge strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    half_next  = half;
    accept     = 1'b0;
    lead       = 1'b0;
    trail      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
          cnt_next   = '0;
        end else begin
          cnt_next = '0;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_next = XFER;
          cnt_next   = '0;
          half_next  = '0;
          lead       = 1'b1;
        end else begin
          cnt_next = cnt + DIV_W'(1);
        end
      end
      XFER: begin
        if (half_end) begin
          cnt_next = '0;
          if (half == LAST_HALF) begin
            state_next = HOLD;
          end else begin
            half_next = half + HALF_W'(1);
            // Entering an odd half-period is a trailing edge, even is leading.
            if (half[0]) lead  = 1'b1;
            else         trail = 1'b1;
          end
        end else begin
          cnt_next = cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        if (half_end) begin
          state_next = IDLE;
          cnt_next   = '0;
          finish     = 1'b1;
        end else begin
          cnt_next = cnt + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and divider/half-period counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      half  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      half  <= half_next;
    end
  end

  // Latched transfer settings, shift registers and all registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div     <= '0;
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      lsb_l   <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      MOSI    <= 1'b0;
      SCLK    <= 1'b0;
      SS_n    <= '1;
    end else begin
      done <= finish;
      if (accept) begin
        div    <= clk_div;
        cpol_l <= cpol;
        cpha_l <= cpha;
        lsb_l  <= lsb_first;
        rx_sh  <= '0;
        busy   <= 1'b1;
        SCLK   <= cpol;
        SS_n   <= ss_dec;
        // cpha=0 puts the first bit out before the first SCLK edge.
        if (!cpha) begin
          MOSI  <= out_bit(tx_data, lsb_first);
          tx_sh <= shift_out(tx_data, lsb_first);
        end else begin
          MOSI  <= 1'b0;
          tx_sh <= tx_data;
        end
      end else if (lead || trail) begin
        SCLK <= ~SCLK;
        if (lead ^ cpha_l) begin
          rx_sh <= shift_in(rx_sh, lsb_l, MISO);
        end else begin
          MOSI  <= out_bit(tx_sh, lsb_l);
          tx_sh <= shift_out(tx_sh, lsb_l);
        end
      end else if (finish) begin
        busy    <= 1'b0;
        SS_n    <= '1;
        MOSI    <= 1'b0;
        rx_data <= rx_sh;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: an edge-driven SPI slave model
// supplies MISO and captures MOSI; timing is checked against h = clk_div+1.
module tb_spi_master_multi;
  localparam int D     = 8;
  localparam int NS    = 3;
  localparam int LIMIT = 400;

  logic         clk = 1'b0;
  logic         rst_n, start, cpol, cpha, lsb_first;
  logic [D-1:0] tx_data, rx_data;
  logic [1:0]   ss_sel;
  logic [7:0]   clk_div;
  logic         busy, done, MISO, MOSI, SCLK;
  logic [NS-1:0] SS_n;

  int checks = 0;
  int errors = 0;

  spi_master_multi #(.DATA_W(D), .NUM_SS(NS), .DIV_W(8)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .tx_data(tx_data),
    .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .busy(busy), .done(done), .rx_data(rx_data),
    .MISO(MISO), .MOSI(MOSI), .SCLK(SCLK), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  // Slave model: reacts to SCLK edges using the bench's own record of the mode.
  logic         loop_en = 1'b0;
  logic         slv_miso = 1'b0;
  logic [D-1:0] slv_tx = '0;
  logic [D-1:0] slv_rx = '0;
  int           slv_in = 0, slv_out = 0, slv_edges = 0, slv_rises = 0;
  logic         prev_busy = 1'b0, prev_sclk = 1'b0;
  logic         cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;

  assign MISO = loop_en ? MOSI : slv_miso;

  function automatic int pos(input int i, input logic lsb);
    return lsb ? i : D - 1 - i;
  endfunction

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      slv_in = 0; slv_out = 0; slv_edges = 0; slv_rises = 0; slv_rx = '0;
      if (!cfg_cpha) begin
        slv_miso = slv_tx[pos(0, cfg_lsb)];
        slv_out  = 1;
      end
    end else if (busy === 1'b1 && SCLK !== prev_sclk) begin
      slv_edges++;
      if (SCLK) slv_rises++;
      if ((SCLK !== cfg_cpol) != cfg_cpha) begin
        if (slv_in < D) slv_rx[pos(slv_in, cfg_lsb)] = MOSI;
        slv_in++;
      end else if (slv_out < D) begin
        slv_miso = slv_tx[pos(slv_out, cfg_lsb)];
        slv_out++;
      end
    end
    prev_busy = busy;
    prev_sclk = SCLK;
  end

  function automatic logic [NS-1:0] exp_ss(input logic [1:0] ss);
    logic [NS-1:0] m;
    m = '1;
    if (int'(ss) < NS) m[ss] = 1'b0;
    return m;
  endfunction

  function automatic int exp_lat(input logic [7:0] div);
    return 1 + (2 * D + 2) * (int'(div) + 1);
  endfunction

  // Runs one transfer starting at the current negedge; returns observations.
  task automatic do_xfer(input logic [D-1:0] tx, word, input logic [1:0] ss,
                         input logic cp, ch, lsb, input logic [7:0] div, input bit scramble,
                         output int lat, output logic [D-1:0] rx, cap,
                         output int edges, rises, ss_errs, output logic sclk_first, busy_first);
    logic [NS-1:0] ess;
    int n;
    ess = exp_ss(ss);
    cfg_cpol = cp; cfg_cpha = ch; cfg_lsb = lsb; slv_tx = word;
    tx_data = tx; ss_sel = ss; cpol = cp; cpha = ch; lsb_first = lsb; clk_div = div;
    start = 1'b1;
    lat = -1; ss_errs = 0; n = 0; sclk_first = 1'bx; busy_first = 1'bx;
    while (n < LIMIT) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        busy_first = busy;
        sclk_first = SCLK;
        if (scramble) begin
          tx_data = D'($urandom); ss_sel = 2'($urandom); cpol = 1'($urandom);
          cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = 8'($urandom);
        end
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (SS_n !== ess) ss_errs++;
    end
    rx = rx_data; cap = slv_rx; edges = slv_edges; rises = slv_rises;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    checks++; if (MOSI !== 1'b0)    begin errors++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    checks++; if (SCLK !== 1'b0)    begin errors++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
    checks++; if (SS_n !== 3'b111)  begin errors++; $display("FAIL reset_ss: got %b want 111", SS_n); end
  endtask

  task automatic test_mode0;
    int lat, edges, rises, sse; logic [D-1:0] rx, cap; logic sf, bf;
    loop_en = 1'b1;
    do_xfer(8'hA5, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, lat, rx, cap, edges, rises, sse, sf, bf);
    loop_en = 1'b0;
    checks++; if (lat !== 19)      begin errors++; $display("FAIL mode0_latency: got %0d want 19", lat); end
    checks++; if (rx !== 8'hA5)    begin errors++; $display("FAIL mode0_rx: got %h want a5", rx); end
    checks++; if (cap !== 8'hA5)   begin errors++; $display("FAIL mode0_mosi: got %h want a5", cap); end
    checks++; if (rises !== 8)     begin errors++; $display("FAIL mode0_rises: got %0d want 8", rises); end
    checks++; if (sse !== 0)       begin errors++; $display("FAIL mode0_ss: %0d cycles not 110", sse); end
    checks++; if (bf !== 1'b1)     begin errors++; $display("FAIL mode0_busy: got %b want 1", bf); end
    @(negedge clk);
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL mode0_done_width: got %b want 0", done); end
    checks++; if (MOSI !== 1'b0)   begin errors++; $display("FAIL mode0_idle_mosi: got %b want 0", MOSI); end
  endtask

  task automatic test_mode3;
    int lat, edges, rises, sse; logic [D-1:0] rx, cap; logic sf, bf;
    do_xfer(8'h01, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1, lat, rx, cap, edges, rises, sse, sf, bf);
    checks++; if (sf !== 1'b1)     begin errors++; $display("FAIL mode3_sclk_idle: got %b want 1", sf); end
    checks++; if (lat !== 73)      begin errors++; $display("FAIL mode3_latency: got %0d want 73", lat); end
    checks++; if (rx !== 8'hFF)    begin errors++; $display("FAIL mode3_rx: got %h want ff", rx); end
    checks++; if (cap !== 8'h01)   begin errors++; $display("FAIL mode3_mosi: got %h want 01", cap); end
    checks++; if (SCLK !== 1'b1)   begin errors++; $display("FAIL mode3_sclk_end: got %b want 1", SCLK); end
  endtask

  task automatic test_random;
    int lat, edges, rises, sse; logic [D-1:0] rx, cap, tx, word; logic sf, bf, cp, ch, lsb;
    logic [1:0] ss; logic [7:0] div;
    for (int i = 0; i < 12; i++) begin
      tx = D'($urandom); word = D'($urandom); ss = 2'($urandom_range(0, 3));
      cp = 1'($urandom); ch = 1'($urandom); lsb = 1'($urandom); div = 8'($urandom_range(0, 5));
      do_xfer(tx, word, ss, cp, ch, lsb, div, 1'b1, lat, rx, cap, edges, rises, sse, sf, bf);
      checks++; if (lat !== exp_lat(div)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat(div)); end
      checks++; if (rx !== word)   begin errors++; $display("FAIL rand%0d_rx: got %h want %h", i, rx, word); end
      checks++; if (cap !== tx)    begin errors++; $display("FAIL rand%0d_mosi: got %h want %h", i, cap, tx); end
      checks++; if (edges !== 2*D) begin errors++; $display("FAIL rand%0d_edges: got %0d want %0d", i, edges, 2*D); end
      checks++; if (sse !== 0)     begin errors++; $display("FAIL rand%0d_ss: %0d bad cycles want 0", i, sse); end
      checks++; if (SCLK !== cp)   begin errors++; $display("FAIL rand%0d_sclk_idle: got %b want %b", i, SCLK, cp); end
    end
  endtask

  task automatic test_out_of_range;
    int lat, edges, rises, sse; logic [D-1:0] rx, cap; logic sf, bf;
    do_xfer(8'h96, 8'h3B, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, lat, rx, cap, edges, rises, sse, sf, bf);
    checks++; if (sse !== 0)      begin errors++; $display("FAIL oor_ss: %0d cycles not 111", sse); end
    checks++; if (edges !== 2*D)  begin errors++; $display("FAIL oor_edges: got %0d want %0d", edges, 2*D); end
    checks++; if (lat !== exp_lat(8'd1)) begin errors++; $display("FAIL oor_latency: got %0d want %0d", lat, exp_lat(8'd1)); end
    checks++; if (rx !== 8'h3B)   begin errors++; $display("FAIL oor_rx: got %h want 3b", rx); end
  endtask

  task automatic test_back_to_back;
    int l, ndone;
    logic [D-1:0] word;
    l = exp_lat(8'd1);
    word = D'($urandom);
    cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_lsb = 1'b0; slv_tx = word;
    tx_data = 8'h5A; ss_sel = 2'd2; cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; clk_div = 8'd1;
    start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 3 * l + l / 2; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        checks++; if (n !== ndone * l) begin errors++; $display("FAIL b2b_done_time: got %0d want %0d", n, ndone * l); end
        checks++; if (rx_data !== word) begin errors++; $display("FAIL b2b_rx: got %h want %h", rx_data, word); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ndone); end
    repeat (l + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, edges, rises, sse, nd; logic [D-1:0] rx, cap; logic sf, bf;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb = 1'b0; slv_tx = 8'hE7;
    tx_data = 8'h55; ss_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (SS_n !== 3'b111)  begin errors++; $display("FAIL rstmid_ss: got %b want 111", SS_n); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx: got %h want 00", rx_data); end
    checks++; if ({SCLK, MOSI, done} !== 3'b000) begin errors++; $display("FAIL rstmid_pins: got %b want 000", {SCLK, MOSI, done}); end
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", nd); end
    rst_n = 1'b1;
    do_xfer(8'h3C, 8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, lat, rx, cap, edges, rises, sse, sf, bf);
    checks++; if (lat !== 19)    begin errors++; $display("FAIL rstmid_latency: got %0d want 19", lat); end
    checks++; if (cap !== 8'h3C) begin errors++; $display("FAIL rstmid_mosi: got %h want 3c", cap); end
    checks++; if (rx !== 8'hC3)  begin errors++; $display("FAIL rstmid_rx2: got %h want c3", rx); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_data = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; clk_div = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_mode0();
    test_mode3();
    test_random();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
